mem_burst_controller: RTL and testbench
=======================================

Name: mem_burst_controller

Overview:
Parametrised successor to the kernel memory controller. It serves single, horizontal-burst and vertical-strided reads, plus a horizontal-burst write, against a synchronous single-port RAM, and packs LANES elements into one wide word. It sits between the pipelined CPU's vector/kernel load-store stage and the kernel/data RAM. Completion is signalled with a one-cycle HANDSHAKE pulse.

Parameters:
DATA_W, 16, element width in bits
ADDR_W, 32, address width
LANES, 3, elements per burst; packed word width is LANES*DATA_W
READ_LAT, 1, RAM read latency in cycles (valid range 1..4)

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous reset, active-low
ENABLE  in  1  request valid; sampled only in IDLE
Ctrl  in  2  mode: 00 write-horizontal, 01 read-vertical, 10 read-single, 11 read-horizontal
ADDRESS  in  ADDR_W  base element address
STRIDE  in  ADDR_W  element distance between lanes in vertical mode
WriteData  in  LANES*DATA_W  write payload; lane i = bits [i*DATA_W +: DATA_W]
ReadMem  in  DATA_W  RAM read data
AddressMem  out  ADDR_W  RAM address (registered)
WriteMem  out  DATA_W  RAM write data (registered)
WrEnMem  out  1  RAM write enable (registered)
BUSY  out  1  high from acceptance until the HANDSHAKE cycle, inclusive
HANDSHAKE  out  1  one-cycle completion pulse
READ  out  LANES*DATA_W  packed read result; lane 0 in the LSBs

Behaviour:
- Reset (RESET=0, asynchronous): all outputs 0, state IDLE, internal counters 0. Reset mid-burst aborts with no HANDSHAKE, and READ is cleared.
- States: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE. Write mode skips DRAIN.
- IDLE: on a rising edge with ENABLE=1, latch Ctrl, ADDRESS, STRIDE and WriteData, set n (1 for single, else LANES), go to ISSUE. After acceptance these inputs may be X without effect.
- ISSUE: in cycle i (0..n-1), AddressMem = addr_i.
  - Horizontal: addr_i = base+i. Vertical: addr_i = base+i*STRIDE. Single: addr_0 = base.
  - All address arithmetic is modulo 2^ADDR_W; wrap-around is legal and silent.
  - Write mode: WrEnMem=1 and WriteMem = lane i each ISSUE cycle; WrEnMem is 0 in every other state.
  - After cycle n-1: reads go to DRAIN, writes go to DONE.
- Read capture: ReadMem is sampled at the edge ending cycle i+READ_LAT (counted from ISSUE cycle 0) into lane i. Capture uses a separate counter so issue and capture overlap.
- DRAIN: lasts READ_LAT cycles, until the last lane is captured.
- READ update: lanes not requested (lanes 1..LANES-1 in single mode) are 0. READ changes only on the edge entering DONE and holds until the next read completes or reset. Write requests leave READ unchanged.
- DONE: HANDSHAKE=1 for exactly one cycle, then IDLE.
- Read latency: HANDSHAKE is high in cycle n+READ_LAT after ISSUE cycle 0. Single read with READ_LAT=1: 2 cycles after acceptance.
- Write latency: HANDSHAKE is high in cycle n.
- ENABLE is ignored outside IDLE; deasserting it mid-burst does not abort.
- Back-to-back: ENABLE=1 during DONE is not accepted. The next request is accepted on the edge leaving IDLE, so there is at least one idle cycle between requests.
- Ctrl is fully decoded; there are no illegal codes.

Decomposition:
- Package mem_ctrl_pkg: mode_t enum (MODE_WR_H, MODE_RD_V, MODE_RD_S, MODE_RD_H), state_t enum (IDLE, ISSUE, DRAIN, DONE), and a localparam function for the counter width $clog2(LANES+READ_LAT+1).
- Sub-module mem_addr_gen: latched base and increment (1 or STRIDE), step/load controls, registered address output with modular add.

Test Plan:
All scenarios: LANES=3, READ_LAT=1, RAM of 16 words preloaded mem[a] = 16'h1000+a, RAM addressed by AddressMem[3:0].
- Single: Ctrl=10, ADDRESS=2 -> HANDSHAKE one cycle, 2 cycles after acceptance; READ=48'h0000_0000_1002. ADDRESS driven X after acceptance has no effect.
- Horizontal: Ctrl=11, ADDRESS=4 -> AddressMem 4,5,6 on consecutive cycles; READ=48'h1006_1005_1004; HANDSHAKE 4 cycles after acceptance.
- Vertical: Ctrl=01, ADDRESS=1, STRIDE=4 -> AddressMem 1,5,9; READ=48'h1009_1005_1001.
- Write then read: Ctrl=00, ADDRESS=8, WriteData=48'hAAAA_BBBB_CCCC -> WrEnMem high 3 cycles with WriteMem CCCC, BBBB, AAAA; HANDSHAKE in cycle 3; READ unchanged. Follow with horizontal read at 8 -> READ=48'hAAAA_BBBB_CCCC.
- Wrap: Ctrl=11, ADDRESS=32'hFFFF_FFFF -> AddressMem FFFF_FFFF, 0000_0000, 0000_0001; READ=48'h1001_1000_100F.
- Reset mid-burst: assert RESET=0 during ISSUE cycle 1 of a horizontal read -> outputs 0 immediately, no HANDSHAKE. After release, a fresh single read at 3 returns 48'h0000_0000_1003.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the burst memory controller.
//   mode_t   : request mode, encoded exactly as the Ctrl input.
//   state_t  : controller FSM states.
//   cnt_width: width of the per-burst cycle/lane counters.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_WR_H = 2'b00,
        MODE_RD_V = 2'b01,
        MODE_RD_S = 2'b10,
        MODE_RD_H = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        DRAIN = 2'b10,
        DONE  = 2'b11
    } state_t;

    // Counters must reach lanes+read_lat, the last cycle index of a burst.
    function automatic int cnt_width(input int lanes, input int read_lat);
        return $clog2(lanes + read_lat + 1);
    endfunction

endpackage

// File: rtl/mem_burst_controller_addr_gen.sv
// Burst address generator.
//   clk_i, rst_ni : clock and asynchronous active-low reset
//   load_i        : latch base_i as the current address and inc_i as the step
//   step_i        : advance the address by the latched increment (mod 2^ADDR_W)
//   base_i, inc_i : base address and per-lane increment (1 or STRIDE)
//   addr_o        : registered RAM address
module mem_addr_gen
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] inc_i,
    output logic [ADDR_W-1:0] addr_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] inc_q, inc_d;

    // Next address: load wins over step; the add wraps silently.
    always_comb begin
        addr_d = addr_q;
        inc_d  = inc_q;
        if (load_i) begin
            addr_d = base_i;
            inc_d  = inc_i;
        end else if (step_i) begin
            addr_d = addr_q + inc_q;
        end else begin
            addr_d = addr_q;
        end
    end

    // Address and increment registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q <= {ADDR_W{1'b0}};
            inc_q  <= {ADDR_W{1'b0}};
        end else begin
            addr_q <= addr_d;
            inc_q  <= inc_d;
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/mem_burst_controller.sv
// Burst memory controller: single, horizontal and vertical-strided reads and
// horizontal writes against a synchronous single-port RAM, packing LANES
// elements into one wide word.
//   CLK, RESET          : clock, asynchronous active-low reset
//   ENABLE, Ctrl        : request valid (sampled only in IDLE) and mode
//   ADDRESS, STRIDE     : base element address, vertical lane distance
//   WriteData           : write payload, lane i at [i*DATA_W +: DATA_W]
//   ReadMem             : RAM read data (READ_LAT cycles after the address)
//   AddressMem, WriteMem, WrEnMem : registered RAM interface
//   BUSY, HANDSHAKE     : busy window and one-cycle completion pulse
//   READ                : packed read result, lane 0 in the LSBs
module mem_burst_controller
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 32,
    parameter int LANES    = 3,
    parameter int READ_LAT = 1
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      ENABLE,
    input  logic [1:0]                Ctrl,
    input  logic [ADDR_W-1:0]         ADDRESS,
    input  logic [ADDR_W-1:0]         STRIDE,
    input  logic [LANES*DATA_W-1:0]   WriteData,
    input  logic [DATA_W-1:0]         ReadMem,
    output logic [ADDR_W-1:0]         AddressMem,
    output logic [DATA_W-1:0]         WriteMem,
    output logic                      WrEnMem,
    output logic                      BUSY,
    output logic                      HANDSHAKE,
    output logic [LANES*DATA_W-1:0]   READ
);

    localparam int CNT_W = cnt_width(LANES, READ_LAT);
    localparam int WORD_W = LANES * DATA_W;

    state_t             state_q, state_d;
    mode_t              mode_q, mode_d;
    logic [CNT_W-1:0]   n_q, n_d;        // elements in this burst
    logic [CNT_W-1:0]   cyc_q, cyc_d;    // cycles since ISSUE cycle 0
    logic [CNT_W-1:0]   cap_q, cap_d;    // next lane to capture
    logic [WORD_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  wmem_q, wmem_d;
    logic               wren_q, wren_d;
    logic [WORD_W-1:0]  rdbuf_q, rdbuf_d;
    logic [WORD_W-1:0]  read_q, read_d;
    logic               busy_q, busy_d;
    logic               hs_q, hs_d;

    mode_t              ctrl_mode_s;
    logic [ADDR_W-1:0]  inc_s;
    logic [WORD_W-1:0]  wshift_s;
    logic               cap_en_s;
    logic               load_s;
    logic               step_s;

    assign ctrl_mode_s = mode_t'(Ctrl);
    assign inc_s       = (ctrl_mode_s == MODE_RD_V) ? STRIDE : ADDR_W'(1);
    assign wshift_s    = wdata_q >> DATA_W;

    // Lane i returns READ_LAT cycles after it was issued; the capture counter
    // runs independently of issue so the two overlap.
    assign cap_en_s = ((state_q == ISSUE) || (state_q == DRAIN)) &&
                      (mode_q != MODE_WR_H) &&
                      (cyc_q >= CNT_W'(READ_LAT)) &&
                      (cap_q < n_q);

    mem_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk_i  (CLK),
        .rst_ni (RESET),
        .load_i (load_s),
        .step_i (step_s),
        .base_i (ADDRESS),
        .inc_i  (inc_s),
        .addr_o (AddressMem)
    );

    // Next-state, capture and RAM-control logic.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        n_d     = n_q;
        cyc_d   = cyc_q;
        cap_d   = cap_q;
        wdata_d = wdata_q;
        wmem_d  = wmem_q;
        wren_d  = wren_q;
        rdbuf_d = rdbuf_q;
        read_d  = read_q;
        load_s  = 1'b0;
        step_s  = 1'b0;

        if (cap_en_s) begin
            for (int l = 0; l < LANES; l++) begin
                if (cap_q == CNT_W'(l)) begin
                    rdbuf_d[l*DATA_W +: DATA_W] = ReadMem;
                end else begin
                    rdbuf_d[l*DATA_W +: DATA_W] = rdbuf_q[l*DATA_W +: DATA_W];
                end
            end
            cap_d = cap_q + CNT_W'(1);
        end else begin
            cap_d = cap_q;
        end

        case (state_q)
            IDLE: begin
                if (ENABLE) begin
                    state_d = ISSUE;
                    mode_d  = ctrl_mode_s;
                    n_d     = (ctrl_mode_s == MODE_RD_S) ? CNT_W'(1) : CNT_W'(LANES);
                    cyc_d   = {CNT_W{1'b0}};
                    cap_d   = {CNT_W{1'b0}};
                    wdata_d = WriteData;
                    rdbuf_d = {WORD_W{1'b0}};   // unrequested lanes read as 0
                    load_s  = 1'b1;
                    if (ctrl_mode_s == MODE_WR_H) begin
                        wren_d = 1'b1;
                        wmem_d = WriteData[DATA_W-1:0];
                    end else begin
                        wren_d = 1'b0;
                        wmem_d = wmem_q;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                cyc_d = cyc_q + CNT_W'(1);
                if (cyc_q == n_q - CNT_W'(1)) begin
                    wren_d  = 1'b0;
                    state_d = (mode_q == MODE_WR_H) ? DONE : DRAIN;
                end else begin
                    // Present the next address and write lane for the next cycle.
                    step_s  = 1'b1;
                    wdata_d = wshift_s;
                    wmem_d  = wshift_s[DATA_W-1:0];
                    state_d = ISSUE;
                end
            end
            DRAIN: begin
                cyc_d = cyc_q + CNT_W'(1);
                if (cyc_q == n_q + CNT_W'(READ_LAT) - CNT_W'(1)) begin
                    // Last lane is captured on this same edge, so use the merged buffer.
                    state_d = DONE;
                    read_d  = rdbuf_d;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        hs_d   = (state_d == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            mode_q  <= MODE_WR_H;
            n_q     <= {CNT_W{1'b0}};
            cyc_q   <= {CNT_W{1'b0}};
            cap_q   <= {CNT_W{1'b0}};
            wdata_q <= {WORD_W{1'b0}};
            wmem_q  <= {DATA_W{1'b0}};
            wren_q  <= 1'b0;
            rdbuf_q <= {WORD_W{1'b0}};
            read_q  <= {WORD_W{1'b0}};
            busy_q  <= 1'b0;
            hs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            n_q     <= n_d;
            cyc_q   <= cyc_d;
            cap_q   <= cap_d;
            wdata_q <= wdata_d;
            wmem_q  <= wmem_d;
            wren_q  <= wren_d;
            rdbuf_q <= rdbuf_d;
            read_q  <= read_d;
            busy_q  <= busy_d;
            hs_q    <= hs_d;
        end
    end

    assign WriteMem  = wmem_q;
    assign WrEnMem   = wren_q;
    assign BUSY      = busy_q;
    assign HANDSHAKE = hs_q;
    assign READ      = read_q;

endmodule

// File: tb/tb_mem_burst_controller.sv
module tb_mem_burst_controller;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        ENABLE;
    logic [1:0]  Ctrl;
    logic [31:0] ADDRESS;
    logic [31:0] STRIDE;
    logic [47:0] WriteData;
    logic [15:0] ReadMem;
    logic [31:0] AddressMem;
    logic [15:0] WriteMem;
    logic        WrEnMem;
    logic        BUSY;
    logic        HANDSHAKE;
    logic [47:0] READ;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem [16];

    mem_burst_controller #(
        .DATA_W(16), .ADDR_W(32), .LANES(3), .READ_LAT(1)
    ) dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .Ctrl(Ctrl),
        .ADDRESS(ADDRESS), .STRIDE(STRIDE), .WriteData(WriteData),
        .ReadMem(ReadMem), .AddressMem(AddressMem), .WriteMem(WriteMem),
        .WrEnMem(WrEnMem), .BUSY(BUSY), .HANDSHAKE(HANDSHAKE), .READ(READ)
    );

    always #5 CLK = ~CLK;

    // Synchronous RAM, one cycle read latency, read-before-write.
    initial begin
        for (int a = 0; a < 16; a++) mem[a] = 16'h1000 + 16'(a);
        ReadMem = 16'h0000;
    end
    always @(posedge CLK) begin
        ReadMem <= mem[AddressMem[3:0]];
        if (WrEnMem) mem[AddressMem[3:0]] <= WriteMem;
    end

    // Present a request in IDLE; after the accepting edge the inputs go X.
    task automatic request(input logic [1:0] c, input logic [31:0] a,
                           input logic [31:0] s, input logic [47:0] wd);
        @(negedge CLK);
        ENABLE = 1'b1; Ctrl = c; ADDRESS = a; STRIDE = s; WriteData = wd;
        @(posedge CLK);
        #1;
        ENABLE = 1'b0; Ctrl = 'x; ADDRESS = 'x; STRIDE = 'x; WriteData = 'x;
    endtask

    task automatic test_reset();
        RESET = 1'b0; ENABLE = 1'b0; Ctrl = 2'b00; ADDRESS = 32'd0;
        STRIDE = 32'd0; WriteData = 48'd0;
        #2;
        checks++; if (AddressMem !== 32'd0) begin errors++; $display("FAIL reset_addr got=%h exp=0", AddressMem); end
        checks++; if (WrEnMem !== 1'b0 || WriteMem !== 16'd0) begin errors++; $display("FAIL reset_wr got=%b/%h exp=0/0", WrEnMem, WriteMem); end
        checks++; if (BUSY !== 1'b0 || HANDSHAKE !== 1'b0) begin errors++; $display("FAIL reset_ctl got=%b/%b exp=0/0", BUSY, HANDSHAKE); end
        checks++; if (READ !== 48'd0) begin errors++; $display("FAIL reset_read got=%h exp=0", READ); end
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
    endtask

    task automatic test_single();
        logic e;
        request(2'b10, 32'd2, 32'd0, 48'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            e = (k == 2);
            checks++; if (HANDSHAKE !== e) begin errors++; $display("FAIL single_hs k=%0d got=%b exp=%b", k, HANDSHAKE, e); end
            e = (k <= 2);
            checks++; if (BUSY !== e) begin errors++; $display("FAIL single_busy k=%0d got=%b exp=%b", k, BUSY, e); end
            if (k == 0) begin
                checks++; if (AddressMem !== 32'd2) begin errors++; $display("FAIL single_addr got=%h exp=2", AddressMem); end
            end
        end
        checks++; if (READ !== 48'h0000_0000_1002) begin errors++; $display("FAIL single_read got=%h exp=000000001002", READ); end
    endtask

    task automatic test_horizontal();
        logic e;
        logic [31:0] ea [3] = '{32'd4, 32'd5, 32'd6};
        request(2'b11, 32'd4, 32'd0, 48'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (k < 3) begin
                checks++; if (AddressMem !== ea[k]) begin errors++; $display("FAIL horiz_addr k=%0d got=%h exp=%h", k, AddressMem, ea[k]); end
            end
            if (k == 2) begin
                checks++; if (READ !== 48'h0000_0000_1002) begin errors++; $display("FAIL horiz_hold got=%h exp=000000001002", READ); end
            end
            e = (k == 4);
            checks++; if (HANDSHAKE !== e) begin errors++; $display("FAIL horiz_hs k=%0d got=%b exp=%b", k, HANDSHAKE, e); end
        end
        checks++; if (READ !== 48'h1006_1005_1004) begin errors++; $display("FAIL horiz_read got=%h exp=100610051004", READ); end
    endtask

    task automatic test_vertical();
        logic e;
        logic [31:0] ea [3] = '{32'd1, 32'd5, 32'd9};
        request(2'b01, 32'd1, 32'd4, 48'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (k < 3) begin
                checks++; if (AddressMem !== ea[k]) begin errors++; $display("FAIL vert_addr k=%0d got=%h exp=%h", k, AddressMem, ea[k]); end
            end
            e = (k == 4);
            checks++; if (HANDSHAKE !== e) begin errors++; $display("FAIL vert_hs k=%0d got=%b exp=%b", k, HANDSHAKE, e); end
        end
        checks++; if (READ !== 48'h1009_1005_1001) begin errors++; $display("FAIL vert_read got=%h exp=100910051001", READ); end
    endtask

    task automatic test_write_then_read();
        logic e;
        logic [15:0] ew [3] = '{16'hCCCC, 16'hBBBB, 16'hAAAA};
        request(2'b00, 32'd8, 32'd0, 48'hAAAA_BBBB_CCCC);
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            e = (k < 3);
            checks++; if (WrEnMem !== e) begin errors++; $display("FAIL wr_en k=%0d got=%b exp=%b", k, WrEnMem, e); end
            if (k < 3) begin
                checks++; if (WriteMem !== ew[k]) begin errors++; $display("FAIL wr_data k=%0d got=%h exp=%h", k, WriteMem, ew[k]); end
                checks++; if (AddressMem !== 32'd8 + 32'(k)) begin errors++; $display("FAIL wr_addr k=%0d got=%h exp=%h", k, AddressMem, 32'd8 + 32'(k)); end
            end
            e = (k == 3);
            checks++; if (HANDSHAKE !== e) begin errors++; $display("FAIL wr_hs k=%0d got=%b exp=%b", k, HANDSHAKE, e); end
        end
        checks++; if (READ !== 48'h1009_1005_1001) begin errors++; $display("FAIL wr_read_kept got=%h exp=100910051001", READ); end
        request(2'b11, 32'd8, 32'd0, 48'd0);
        repeat (6) @(negedge CLK);
        checks++; if (READ !== 48'hAAAA_BBBB_CCCC) begin errors++; $display("FAIL wr_readback got=%h exp=aaaabbbbcccc", READ); end
    endtask

    task automatic test_wrap();
        logic [31:0] ea [3] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        request(2'b11, 32'hFFFF_FFFF, 32'd0, 48'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (k < 3) begin
                checks++; if (AddressMem !== ea[k]) begin errors++; $display("FAIL wrap_addr k=%0d got=%h exp=%h", k, AddressMem, ea[k]); end
            end
        end
        checks++; if (READ !== 48'h1001_1000_100F) begin errors++; $display("FAIL wrap_read got=%h exp=10011000100f", READ); end
    endtask

    task automatic test_back_to_back();
        logic e;
        @(negedge CLK);
        ENABLE = 1'b1; Ctrl = 2'b10; ADDRESS = 32'd5; STRIDE = 32'd0; WriteData = 48'd0;
        @(posedge CLK);
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            e = (k <= 2) || (k >= 4 && k <= 6);
            checks++; if (BUSY !== e) begin errors++; $display("FAIL b2b_busy k=%0d got=%b exp=%b", k, BUSY, e); end
            e = (k == 2) || (k == 6);
            checks++; if (HANDSHAKE !== e) begin errors++; $display("FAIL b2b_hs k=%0d got=%b exp=%b", k, HANDSHAKE, e); end
            if (k == 6) ENABLE = 1'b0;
        end
        checks++; if (READ !== 48'h0000_0000_1005) begin errors++; $display("FAIL b2b_read got=%h exp=000000001005", READ); end
    endtask

    task automatic test_reset_mid();
        logic e;
        int hs_seen = 0;
        request(2'b11, 32'd0, 32'd0, 48'd0);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        checks++; if (AddressMem !== 32'd0) begin errors++; $display("FAIL rmid_addr got=%h exp=0", AddressMem); end
        checks++; if (BUSY !== 1'b0 || HANDSHAKE !== 1'b0 || WrEnMem !== 1'b0) begin errors++; $display("FAIL rmid_ctl got=%b/%b/%b exp=0/0/0", BUSY, HANDSHAKE, WrEnMem); end
        checks++; if (READ !== 48'd0) begin errors++; $display("FAIL rmid_read got=%h exp=0", READ); end
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            if (HANDSHAKE === 1'b1) hs_seen++;
        end
        RESET = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            if (HANDSHAKE === 1'b1) hs_seen++;
        end
        checks++; if (hs_seen !== 0) begin errors++; $display("FAIL rmid_no_hs got=%0d exp=0", hs_seen); end
        request(2'b10, 32'd3, 32'd0, 48'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            e = (k == 2);
            checks++; if (HANDSHAKE !== e) begin errors++; $display("FAIL rmid_hs k=%0d got=%b exp=%b", k, HANDSHAKE, e); end
        end
        checks++; if (READ !== 48'h0000_0000_1003) begin errors++; $display("FAIL rmid_single got=%h exp=000000001003", READ); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_horizontal();
        test_vertical();
        test_write_then_read();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
